// File: rtl/pair_logic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : pair_logic_pipe
//  Purpose  : NCH-channel, WIDTH-bit bitwise pair-logic cell
//             (out1 = in1 op1 in2, out2 = in3 op2 in4). Results are computed
//             at the accept edge and buffered in a DEPTH-entry FIFO behind a
//             valid/ready handshake. The ops are selectable at runtime.
//  Ports    : clk, rst_n (async assert, active low)
//             cfg_we, cfg_op1, cfg_op2   - op select load (0 AND, 1 OR,
//                                          2 XOR, 3 NAND)
//             in_valid/in_ready, in1..in4 - operand beat (NCH*WIDTH each)
//             out_valid/out_ready, out1/out2 - result beat (NCH*WIDTH each)
//             xfer_cnt                    - output handshake count
//  Options  : PAIR_LOGIC_PIPE_XFER_CNT_EN - saturating handshake counter on
//             xfer_cnt; without it, xfer_cnt is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pair_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_op1,
  input  logic [1:0]             cfg_op2,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH*WIDTH-1:0]   in1,
  input  logic [NCH*WIDTH-1:0]   in2,
  input  logic [NCH*WIDTH-1:0]   in3,
  input  logic [NCH*WIDTH-1:0]   in4,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*WIDTH-1:0]   out1,
  output logic [NCH*WIDTH-1:0]   out2,
  output logic [CNTW-1:0]        xfer_cnt
);

  localparam int DW = NCH * WIDTH;
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0]  c_OP_AND  = 2'd0;
  localparam logic [1:0]  c_OP_OR   = 2'd1;
  localparam logic [1:0]  c_OP_XOR  = 2'd2;
  localparam logic [1:0]  c_OP_NAND = 2'd3;
  localparam logic [AW:0] c_PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Op registers; reset values reproduce the legacy AND / OR cell.
  logic [1:0] r_op1;
  logic [1:0] r_op2;

  logic [DW-1:0] r_mem1 [DEPTH];
  logic [DW-1:0] r_mem2 [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  // Last popped head, presented while the FIFO is empty.
  logic [DW-1:0] r_hold1;
  logic [DW-1:0] r_hold2;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_res1;
  logic [DW-1:0] w_res2;
  logic [DW-1:0] w_head1;
  logic [DW-1:0] w_head2;

  function automatic logic [DW-1:0] f_op(input logic [1:0]    op,
                                         input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      c_OP_AND:  r = a & b;
      c_OP_OR:   r = a | b;
      c_OP_XOR:  r = a ^ b;
      c_OP_NAND: r = ~(a & b);
      default:   r = '0;
    endcase
    return r;
  endfunction

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && !w_full;
  assign w_pop     = out_ready && !w_empty;

  // Results use the op registers as they stand before this edge, so a
  // cfg_we in the same cycle only affects later beats.
  assign w_res1 = f_op(r_op1, in1, in2);
  assign w_res2 = f_op(r_op2, in3, in4);

  assign w_head1 = r_mem1[r_rd_ptr[AW-1:0]];
  assign w_head2 = r_mem2[r_rd_ptr[AW-1:0]];
  assign out1    = w_empty ? r_hold1 : w_head1;
  assign out2    = w_empty ? r_hold2 : w_head2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1 <= c_OP_AND;
      r_op2 <= c_OP_OR;
    end else if (cfg_we) begin
      r_op1 <= cfg_op1;
      r_op2 <= cfg_op2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_hold1  <= '0;
      r_hold2  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem1[i] <= '0;
        r_mem2[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem1[r_wr_ptr[AW-1:0]] <= w_res1;
        r_mem2[r_wr_ptr[AW-1:0]] <= w_res2;
        r_wr_ptr                 <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_hold1  <= w_head1;
        r_hold2  <= w_head2;
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

`ifdef PAIR_LOGIC_PIPE_XFER_CNT_EN
  logic [CNTW-1:0] r_xfer_cnt;

  // Saturating: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_pop && (r_xfer_cnt != {CNTW{1'b1}})) begin
      r_xfer_cnt <= r_xfer_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`else
  assign xfer_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pair_logic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pair_logic_pipe
//  Purpose  : Directed self-checking bench for pair_logic_pipe
//             (WIDTH=8, NCH=4, DEPTH=4, CNTW=4). Honours
//             PAIR_LOGIC_PIPE_XFER_CNT_EN for the counter expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pair_logic_pipe;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int CNTW  = 4;
  localparam int DW    = NCH * WIDTH;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_op1;
  logic [1:0]    cfg_op2;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in1;
  logic [DW-1:0] in2;
  logic [DW-1:0] in3;
  logic [DW-1:0] in4;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out1;
  logic [DW-1:0] out2;
  logic [CNTW-1:0] xfer_cnt;

  int checks   = 0;
  int failures = 0;

  pair_logic_pipe #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_op1   (cfg_op1),
    .cfg_op2   (cfg_op2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          cfg;
    logic [1:0]    op1;
    logic [1:0]    op2;
    logic [DW-1:0] a1;
    logic [DW-1:0] a2;
    logic [DW-1:0] a3;
    logic [DW-1:0] a4;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we   = 1'b0;
    cfg_op1  = 2'd0;
    cfg_op2  = 2'd0;
    in_valid = 1'b0;
    in1 = '0; in2 = '0; in3 = '0; in4 = '0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  vec_t vecs [5];

  initial begin
    logic [CNTW-1:0] exp_cnt;

    vecs[0] = '{1'b0, 2'd0, 2'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00000001, 32'h80000000,
                32'h0F000F00, 32'h80000001};
    vecs[1] = '{1'b1, 2'd2, 2'd3, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF,
                32'h55555555, 32'hFFFF0000};
    vecs[2] = '{1'b1, 2'd1, 2'd2, 32'h12345678, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFF00FF00,
                32'h1F3F5F7F, 32'h0FF00FF0};
    vecs[3] = '{1'b1, 2'd3, 2'd0, 32'hFFFF0000, 32'hFF00FF00, 32'hDEADBEEF, 32'hFFFF0000,
                32'h00FFFFFF, 32'hDEAD0000};
    vecs[4] = '{1'b1, 2'd2, 2'd2, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000000, 32'hFFFFFFFF,
                32'h00000000, 32'hFFFFFFFF};

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out1",      64'(out1),      64'd0);
    chk("rst_out2",      64'(out2),      64'd0);
    chk("rst_xfer_cnt",  64'(xfer_cnt),  64'd0);

    // ---------------- table-driven op vectors ----------------
    // Vector 0 relies on the reset ops (legacy AND / OR).
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].cfg) begin
        cfg_we  = 1'b1;
        cfg_op1 = vecs[i].op1;
        cfg_op2 = vecs[i].op2;
        step();
        cfg_we  = 1'b0;
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in1 = vecs[i].a1; in2 = vecs[i].a2; in3 = vecs[i].a3; in4 = vecs[i].a4;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_out1", i),  64'(out1), 64'(vecs[i].exp1));
      chk($sformatf("vec%0d_out2", i),  64'(out2), 64'(vecs[i].exp2));
      step();
      chk($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
    end

    // ---------------- op switch in the accept cycle ----------------
    do_reset();
    out_ready = 1'b0;
    cfg_we = 1'b1; cfg_op1 = 2'd2; cfg_op2 = 2'd3;
    in_valid = 1'b1;
    in1 = 32'hFF00FF00; in2 = 32'h0F0F0F0F; in3 = 32'h00000001; in4 = 32'h80000000;
    step();
    cfg_we = 1'b0;
    in1 = 32'hAAAAAAAA; in2 = 32'hFFFFFFFF; in3 = 32'hFFFFFFFF; in4 = 32'h0000FFFF;
    step();
    in_valid = 1'b0;
    chk("sw_A_out1", 64'(out1), 64'h0F000F00);
    chk("sw_A_out2", 64'(out2), 64'h80000001);
    step();
    chk("sw_A_stable", 64'(out1), 64'h0F000F00);
    out_ready = 1'b1;
    step();
    chk("sw_B_out1", 64'(out1), 64'h55555555);
    chk("sw_B_out2", 64'(out2), 64'hFFFF0000);
    step();
    chk("sw_empty", 64'(out_valid), 64'd0);
    chk("sw_hold_out1", 64'(out1), 64'h55555555);

    // ---------------- backpressure fill ----------------
    // AND with all-ones passes in1 straight through.
    do_reset();
    out_ready = 1'b0;
    in2 = '1; in3 = '0; in4 = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in1 = DW'(i + 1);
      chk($sformatf("bp_ready_before%0d", i), 64'(in_ready), 64'd1);
      step();
    end
    in1 = DW'(5);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    step();
    chk("bp_held_ready", 64'(in_ready), 64'd0);
    chk("bp_head1", 64'(out1), 64'd1);
    out_ready = 1'b1;
    chk("bp_full_with_oready", 64'(in_ready), 64'd0);
    step();
    chk("bp_after_pop_ready", 64'(in_ready), 64'd1);
    chk("bp_head2", 64'(out1), 64'd2);
    step();
    in_valid = 1'b0;
    chk("bp_head3", 64'(out1), 64'd3);
    step();
    chk("bp_head4", 64'(out1), 64'd4);
    step();
    chk("bp_head5", 64'(out1), 64'd5);
    chk("bp_head5_valid", 64'(out_valid), 64'd1);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // ---------------- streaming ----------------
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in2 = '1;
    for (int k = 0; k < 20; k++) begin
      in1 = DW'(32'h100 + k);
      step();
      chk($sformatf("stream%0d", k), {31'd0, out_valid, out1}, {31'd0, 1'b1, DW'(32'h100 + k)});
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_empty", 64'(out_valid), 64'd0);

    // ---------------- async reset mid-operation ----------------
    do_reset();
    cfg_we = 1'b1; cfg_op1 = 2'd2; cfg_op2 = 2'd3;
    step();
    cfg_we = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in1 = 32'h11111111; in2 = 32'h22222222; in3 = 32'h0; in4 = 32'h0;
    repeat (3) step();
    in_valid = 1'b0;
    chk("ar_buffered_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_valid", 64'(out_valid), 64'd0);
    chk("ar_async_ready", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in1 = 32'hFF00FF00; in2 = 32'h0F0F0F0F; in3 = 32'h00000001; in4 = 32'h80000000;
    step();
    in_valid = 1'b0;
    chk("ar_post_out1", 64'(out1), 64'h0F000F00);
    chk("ar_post_out2", 64'(out2), 64'h80000001);
    step();

    // ---------------- transfer counter ----------------
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in2 = '1;
    // First edge pushes only; each later edge pushes and pops.
    repeat (6) step();
`ifdef PAIR_LOGIC_PIPE_XFER_CNT_EN
    exp_cnt = 4'd5;
`else
    exp_cnt = 4'd0;
`endif
    chk("cnt_mid", 64'(xfer_cnt), 64'(exp_cnt));
    repeat (11) step();
    in_valid = 1'b0;
    step();
    step();
`ifdef PAIR_LOGIC_PIPE_XFER_CNT_EN
    exp_cnt = 4'd15;
`else
    exp_cnt = 4'd0;
`endif
    chk("cnt_final", 64'(xfer_cnt), 64'(exp_cnt));
    chk("cnt_drained", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("cnt_reset", 64'(xfer_cnt), 64'd0);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pair_logic_pipe.md
Name: pair_logic_pipe

Overview:
- Parametrised, pipelined successor to the two-output pair-logic cell (out1 = in1 op in2, out2 = in3 op in4).
- Generalised to NCH independent channels of WIDTH bits each, with a runtime-selectable bitwise op per output.
- Results are buffered in a DEPTH-entry output FIFO behind a valid/ready handshake.
- Sits between operand producers and downstream consumers that may stall.

Parameters:
- WIDTH, 8: bits per operand per channel.
- NCH, 4: channel count; all channels share one handshake.
- DEPTH, 4: result FIFO entries; power of 2, >= 2.
- CNTW, 16: width of the optional transfer counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_we  input  1  load op selects this cycle.
- cfg_op1  input  2  op for out1: 0 AND, 1 OR, 2 XOR, 3 NAND.
- cfg_op2  input  2  op for out2, same encoding.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in1, in2, in3, in4  input  NCH*WIDTH each  operands; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the beat.
- out1, out2  output  NCH*WIDTH each  results, same channel packing.
- xfer_cnt  output  CNTW  count of output handshakes (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; out_valid=0; in_ready=1; out1=out2=0.
  - op1 reset value is 0 (AND); op2 reset value is 1 (OR). This reproduces legacy pair-logic behaviour.
  - xfer_cnt=0.
- Config:
  - On a cycle with cfg_we=1, op1/op2 registers update at the edge.
  - The new ops apply to beats accepted in later cycles. The accept in the same cycle as cfg_we uses the old ops.
  - Results already in the FIFO are never recomputed.
- Compute:
  - Results are evaluated combinationally from the inputs and current op registers at the accept edge, then stored.
  - Ops are applied bitwise across all NCH*WIDTH bits; there is no cross-bit or cross-channel interaction.
- Accept: an input beat is accepted when in_valid & in_ready.
  - in_ready = !full. It is a registered-state function and does not depend on out_ready, so there is no combinational ready path.
- Output:
  - out_valid = !empty. out1/out2 present the head entry.
  - Pop occurs on out_valid & out_ready. Outputs are stable while out_valid=1 and out_ready=0.
- Latency: a beat accepted at edge N into an empty FIFO shows out_valid=1 after edge N (visible in cycle N+1). There is no same-cycle pass-through.
- Throughput: 1 beat/cycle sustained when out_ready is held high.
- Occupancy:
  - Simultaneous push and pop: count unchanged, and both pointers advance.
  - When full, in_ready=0 even if out_ready=1 in that cycle.
  - When empty, out_ready is ignored.
- Pointers: log2(DEPTH)+1 bits with natural wrap. Full = MSBs differ and the rest are equal; empty = pointers equal.
- Reset mid-operation: all buffered results are discarded immediately and ops return to their reset values.
- X-safety: out1/out2 hold their last head value when empty. Verify only while out_valid=1.

Optional Feature:
- Macro: PAIR_LOGIC_PIPE_XFER_CNT_EN.
- When defined:
  - xfer_cnt increments on every output handshake.
  - It saturates at 2^CNTW-1 and does not wrap.
  - Reset clears it.
- When undefined: xfer_cnt is tied to 0, and no counter flops are synthesised.

Test Plan:
- Reset then legacy ops: WIDTH=8, NCH=4, in1=0xFF00FF00, in2=0x0F0F0F0F, in3=0x00000001, in4=0x80000000, out_ready=1 -> next cycle out_valid=1, out1=0x0F000F00, out2=0x80000001.
- Op switch: cfg_we=1 with op1=2 (XOR), op2=3 (NAND), and beat A accepted in the same cycle; beat B the next cycle with in1=0xAAAAAAAA, in2=0xFFFFFFFF, in3=0xFFFFFFFF, in4=0x0000FFFF -> A uses AND/OR; B gives out1=0x55555555, out2=0xFFFF0000.
- Backpressure fill: out_ready=0, push 5 beats at DEPTH=4 -> in_ready drops after the 4th accept, and the 5th beat is held. Raise out_ready -> results emerge in order, and the 5th is accepted the cycle after the first pop.
- Streaming: in_valid=out_ready=1 for 20 cycles with an incrementing in1 and in2=all-ones -> 20 consecutive out beats with out1 equal to the in1 sequence, no bubbles after the first.
- Async reset while 3 entries are buffered: pull rst_n low mid-cycle -> out_valid=0 and in_ready=1 immediately, without waiting for clk. The first beat after release uses AND/OR.
- With PAIR_LOGIC_PIPE_XFER_CNT_EN, CNTW=4: 17 output handshakes -> xfer_cnt=15 (saturated). Without the macro -> xfer_cnt=0 throughout.
